// File: rtl/cpu16_mem_arbiter.sv
// Arbiter for cpu16 fetch, cpu16 data and debug traffic onto sram, vram and the ctrl register.
// Writes and reads each get one combinational grant per cycle. The rdy pulses follow one cycle later.
module cpu16_mem_arbiter #(
  parameter int unsigned INS_MAX_WAIT = 3,
  parameter logic [15:0] UNMAP_DATA   = 16'hEEEE
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] ins_rd_addr,
  input  logic        ins_rd_req,
  output logic        ins_rd_rdy,
  output logic [15:0] ins_rd_data,
  input  logic [15:0] dat_rw_addr,
  input  logic [15:0] dat_wr_data,
  input  logic        dat_rd_req,
  output logic        dat_rd_rdy,
  output logic [15:0] dat_rd_data,
  input  logic        dat_wr_req,
  output logic        dat_wr_rdy,
  input  logic        dbg_we,
  input  logic [15:0] dbg_waddr,
  input  logic [15:0] dbg_wdata,
  output logic [15:0] sram_raddr,
  output logic        sram_re,
  input  logic [15:0] sram_rdata,
  output logic [15:0] sram_waddr,
  output logic [15:0] sram_wdata,
  output logic        sram_we,
  output logic [10:0] vram_waddr,
  output logic [7:0]  vram_wdata,
  output logic        vram_we,
  output logic        cpu_reset
);

  localparam int CW = (INS_MAX_WAIT < 1) ? 1 : $clog2(INS_MAX_WAIT + 1);
  localparam logic [CW-1:0] WAIT_MAX = CW'(INS_MAX_WAIT);

  typedef enum logic [1:0] {REG_SRAM, REG_VRAM, REG_CTRL, REG_UNMAP} region_e;
  typedef enum logic [1:0] {SRC_NONE, SRC_INS, SRC_DAT} src_e;

  function automatic region_e decode(input logic [15:0] addr);
    case (addr[15:12])
      4'h0:    return REG_SRAM;
      4'h8:    return REG_VRAM;
      4'hF:    return REG_CTRL;
      default: return REG_UNMAP;
    endcase
  endfunction

  logic          wr_dbg, wr_cpu, ctrl_we;
  logic [15:0]   wr_addr, wr_data;
  region_e       wr_region;

  logic          ins_valid, dat_valid, ins_gnt, dat_gnt;
  logic [15:0]   rd_addr;
  region_e       rd_region, rd_region_q;
  src_e          rd_src_nxt, rd_src_q;
  logic [CW-1:0] wait_cnt, wait_cnt_nxt;
  logic          wr_rdy_q;
  logic [15:0]   rd_data;

  // Write path. The debug port always wins. A cpu write is ignored while the cpu is held in reset.
  // NOTE: every signal in an always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    wr_dbg    = 1'b0;
    wr_cpu    = 1'b0;
    wr_addr   = dat_rw_addr;
    wr_data   = dat_wr_data;
    if (reset_n) begin
      wr_dbg = dbg_we;
      wr_cpu = !dbg_we && dat_wr_req && !cpu_reset;
    end
    if (wr_dbg) begin
      wr_addr = dbg_waddr;
      wr_data = dbg_wdata;
    end
    wr_region = decode(wr_addr);
    sram_we   = (wr_dbg || wr_cpu) && (wr_region == REG_SRAM);
    vram_we   = (wr_dbg || wr_cpu) && (wr_region == REG_VRAM);
    ctrl_we   = (wr_dbg || wr_cpu) && (wr_region == REG_CTRL);
  end

  assign sram_waddr = wr_addr;
  assign sram_wdata = wr_data;
  assign vram_waddr = wr_addr[10:0];
  assign vram_wdata = wr_data[7:0];

  // Read path. A data read normally wins, but it is blocked while a data write is pending.
  // A fetch that has waited WAIT_MAX cycles takes the port.
  always_comb begin
    ins_valid    = reset_n && ins_rd_req && !cpu_reset;
    dat_valid    = reset_n && dat_rd_req && !dat_wr_req && !cpu_reset;
    ins_gnt      = ins_valid && (!dat_valid || (wait_cnt == WAIT_MAX));
    dat_gnt      = dat_valid && !ins_gnt;
    rd_addr      = ins_gnt ? ins_rd_addr : dat_rw_addr;
    rd_region    = decode(rd_addr);
    sram_re      = (ins_gnt || dat_gnt) && (rd_region == REG_SRAM);
    rd_src_nxt   = SRC_NONE;
    if (ins_gnt)      rd_src_nxt = SRC_INS;
    else if (dat_gnt) rd_src_nxt = SRC_DAT;
    wait_cnt_nxt = '0;
    if (ins_valid && !ins_gnt) wait_cnt_nxt = wait_cnt + 1'b1;
  end

  assign sram_raddr = rd_addr;

  // NOTE: sequential state uses non-blocking assignments only. The async reset clears every flop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cpu_reset   <= 1'b0;
      wait_cnt    <= '0;
      rd_src_q    <= SRC_NONE;
      rd_region_q <= REG_UNMAP;
      wr_rdy_q    <= 1'b0;
    end else begin
      if (ctrl_we) cpu_reset <= wr_data[0];
      wait_cnt    <= wait_cnt_nxt;
      rd_src_q    <= rd_src_nxt;
      rd_region_q <= rd_region;
      wr_rdy_q    <= wr_cpu;
    end
  end

  // Read data is steered from the registered region.
  // The ctrl value is the live register, which is 0 whenever a cpu rdy can be seen.
  always_comb begin
    rd_data = UNMAP_DATA;
    case (rd_region_q)
      REG_SRAM: rd_data = sram_rdata;
      REG_CTRL: rd_data = {15'b0, cpu_reset};
      default:  rd_data = UNMAP_DATA;
    endcase
  end

  assign ins_rd_data = rd_data;
  assign dat_rd_data = rd_data;
  assign ins_rd_rdy  = (rd_src_q == SRC_INS) && !cpu_reset;
  assign dat_rd_rdy  = (rd_src_q == SRC_DAT) && !cpu_reset;
  assign dat_wr_rdy  = wr_rdy_q && !cpu_reset;

endmodule

// File: tb/tb_cpu16_mem_arbiter.sv
// Scoreboard bench for cpu16_mem_arbiter: directed stimulus pushes expected reads and writes.
// Negedge monitors pop and compare them as the DUT presents rdy or write strobes.
module tb_cpu16_mem_arbiter;

  typedef enum bit {SRC_INS, SRC_DAT} src_e;
  typedef struct { src_e src; logic [15:0] data; } rd_exp_t;
  typedef struct { bit vram; bit cpu; logic [15:0] addr; logic [15:0] data; } wr_exp_t;

  logic        clk = 1'b0, reset_n = 1'b0;
  logic [15:0] ins_rd_addr = '0, dat_rw_addr = '0, dat_wr_data = '0;
  logic        ins_rd_req = 1'b0, dat_rd_req = 1'b0, dat_wr_req = 1'b0, dbg_we = 1'b0;
  logic [15:0] dbg_waddr = '0, dbg_wdata = '0, sram_rdata = '0;
  logic        ins_rd_rdy, dat_rd_rdy, dat_wr_rdy, sram_re, sram_we, vram_we, cpu_reset;
  logic [15:0] ins_rd_data, dat_rd_data, sram_raddr, sram_waddr, sram_wdata;
  logic [10:0] vram_waddr;
  logic [7:0]  vram_wdata;

  rd_exp_t rd_q[$];
  wr_exp_t wr_q[$];
  bit      wr_rdy_due = 1'b0;
  int      n_checks = 0, n_fail = 0;
  logic [15:0] mem [0:4095];

  always #5 clk = ~clk;

  cpu16_mem_arbiter #(.INS_MAX_WAIT(3), .UNMAP_DATA(16'hEEEE)) dut (
    .clk(clk), .reset_n(reset_n),
    .ins_rd_addr(ins_rd_addr), .ins_rd_req(ins_rd_req), .ins_rd_rdy(ins_rd_rdy), .ins_rd_data(ins_rd_data),
    .dat_rw_addr(dat_rw_addr), .dat_wr_data(dat_wr_data), .dat_rd_req(dat_rd_req),
    .dat_rd_rdy(dat_rd_rdy), .dat_rd_data(dat_rd_data), .dat_wr_req(dat_wr_req), .dat_wr_rdy(dat_wr_rdy),
    .dbg_we(dbg_we), .dbg_waddr(dbg_waddr), .dbg_wdata(dbg_wdata),
    .sram_raddr(sram_raddr), .sram_re(sram_re), .sram_rdata(sram_rdata),
    .sram_waddr(sram_waddr), .sram_wdata(sram_wdata), .sram_we(sram_we),
    .vram_waddr(vram_waddr), .vram_wdata(vram_wdata), .vram_we(vram_we), .cpu_reset(cpu_reset)
  );

  // Behavioural sram: one-cycle read latency, synchronous write.
  always @(posedge clk) begin
    if (sram_re) sram_rdata <= mem[sram_raddr[11:0]];
    if (sram_we) mem[sram_waddr[11:0]] <= sram_wdata;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_rd(input src_e s, input logic [15:0] d);
    rd_exp_t e;
    e.src = s;
    e.data = d;
    rd_q.push_back(e);
  endtask

  task automatic push_wr(input bit v, input bit c, input logic [15:0] a, input logic [15:0] d);
    wr_exp_t e;
    e.vram = v;
    e.cpu = c;
    e.addr = a;
    e.data = d;
    wr_q.push_back(e);
  endtask

  // Read monitor
  always @(negedge clk) begin
    if (reset_n && (ins_rd_rdy || dat_rd_rdy)) begin
      if (rd_q.size() == 0) begin
        check("rd_unexpected", {30'b0, ins_rd_rdy, dat_rd_rdy}, 32'd0);
      end else begin
        rd_exp_t e;
        e = rd_q.pop_front();
        check("rd_source", {30'b0, ins_rd_rdy, dat_rd_rdy}, (e.src == SRC_INS) ? 32'd2 : 32'd1);
        check("rd_data", ins_rd_rdy ? ins_rd_data : dat_rd_data, {16'b0, e.data});
      end
    end
  end

  // Write monitor; a cpu write must be followed by dat_wr_rdy exactly one cycle later
  always @(negedge clk) begin
    if (!reset_n) begin
      wr_rdy_due = 1'b0;
    end else begin
      if (dat_wr_rdy || wr_rdy_due) check("dat_wr_rdy", {31'b0, dat_wr_rdy}, {31'b0, wr_rdy_due});
      wr_rdy_due = 1'b0;
      if (sram_we || vram_we) begin
        if (wr_q.size() == 0) begin
          check("wr_unexpected", {30'b0, vram_we, sram_we}, 32'd0);
        end else begin
          wr_exp_t e;
          e = wr_q.pop_front();
          check("wr_target", {30'b0, vram_we, sram_we}, e.vram ? 32'd2 : 32'd1);
          check("wr_addr", vram_we ? {5'b0, vram_waddr} : sram_waddr, {16'b0, e.addr});
          check("wr_data", vram_we ? {8'b0, vram_wdata} : sram_wdata, {16'b0, e.data});
          wr_rdy_due = e.cpu;
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = '0;
    mem[12'h010] = 16'h1234;
    mem[12'h020] = 16'hA001;
    mem[12'h030] = 16'hD001;

    // Reset state
    repeat (2) tick();
    check("rst_ins_rdy", {31'b0, ins_rd_rdy}, 32'd0);
    check("rst_dat_rdy", {30'b0, dat_rd_rdy, dat_wr_rdy}, 32'd0);
    check("rst_strobes", {29'b0, sram_re, sram_we, vram_we}, 32'd0);
    check("rst_cpu_reset", {31'b0, cpu_reset}, 32'd0);
    reset_n = 1'b1;
    tick();

    // Single fetch: sram_re this cycle, rdy and data next cycle
    ins_rd_addr = 16'h0010; ins_rd_req = 1'b1;
    push_rd(SRC_INS, 16'h1234);
    @(negedge clk);
    check("fetch_sram_re", {31'b0, sram_re}, 32'd1);
    check("fetch_raddr", {16'b0, sram_raddr}, 32'h0010);
    tick();
    ins_rd_req = 1'b0;
    repeat (3) tick();

    // Fetch and data read held together: dat, dat, dat, ins, then repeat
    ins_rd_addr = 16'h0020; dat_rw_addr = 16'h0030;
    ins_rd_req = 1'b1; dat_rd_req = 1'b1;
    for (int k = 0; k < 8; k++) push_rd((k % 4 == 3) ? SRC_INS : SRC_DAT, (k % 4 == 3) ? 16'hA001 : 16'hD001);
    repeat (8) tick();
    ins_rd_req = 1'b0; dat_rd_req = 1'b0;
    repeat (3) tick();

    // Debug write to vram stalls the cpu write for one cycle. Then read the cpu write back.
    dbg_we = 1'b1; dbg_waddr = 16'h8005; dbg_wdata = 16'h00AB;
    dat_wr_req = 1'b1; dat_rw_addr = 16'h0002; dat_wr_data = 16'h5555;
    push_wr(1'b1, 1'b0, 16'h0005, 16'h00AB);
    push_wr(1'b0, 1'b1, 16'h0002, 16'h5555);
    tick();
    dbg_we = 1'b0;
    tick();
    dat_wr_req = 1'b0; dat_rd_req = 1'b1;
    push_rd(SRC_DAT, 16'h5555);
    tick();
    dat_rd_req = 1'b0;
    repeat (3) tick();

    // Data read and write together: write first, read next cycle sees the new value
    dat_rw_addr = 16'h0003; dat_wr_data = 16'h7777;
    dat_wr_req = 1'b1; dat_rd_req = 1'b1;
    push_wr(1'b0, 1'b1, 16'h0003, 16'h7777);
    push_rd(SRC_DAT, 16'h7777);
    tick();
    dat_wr_req = 1'b0;
    tick();
    dat_rd_req = 1'b0;
    repeat (3) tick();

    // cpu_reset set by debugger: held cpu requests get nothing until it is cleared
    dbg_we = 1'b1; dbg_waddr = 16'hF000; dbg_wdata = 16'h0001;
    tick();
    dbg_we = 1'b0;
    check("cpu_reset_set", {31'b0, cpu_reset}, 32'd1);
    ins_rd_addr = 16'h0010; ins_rd_req = 1'b1;
    dat_rw_addr = 16'h0004; dat_wr_data = 16'h9999; dat_rd_req = 1'b1; dat_wr_req = 1'b1;
    @(negedge clk);
    check("halted_no_sram_re", {31'b0, sram_re}, 32'd0);
    repeat (4) tick();
    dat_rd_req = 1'b0; dat_wr_req = 1'b0;
    dbg_we = 1'b1; dbg_wdata = 16'h0000;
    tick();
    dbg_we = 1'b0;
    check("cpu_reset_clear", {31'b0, cpu_reset}, 32'd0);
    push_rd(SRC_INS, 16'h1234);
    tick();
    ins_rd_req = 1'b0;
    repeat (3) tick();

    // A fetch granted in the same cycle cpu_reset is set has its rdy suppressed
    ins_rd_req = 1'b1; dbg_we = 1'b1; dbg_wdata = 16'h0001;
    tick();
    ins_rd_req = 1'b0; dbg_we = 1'b0;
    @(negedge clk);
    check("inflight_suppressed", {31'b0, ins_rd_rdy}, 32'd0);
    tick();
    dbg_we = 1'b1; dbg_wdata = 16'h0000;
    tick();
    dbg_we = 1'b0;
    repeat (2) tick();

    // Back-to-back reads of ctrl, vram and unmapped space: no sram_re is issued
    dat_rd_req = 1'b1;
    dat_rw_addr = 16'hF000; push_rd(SRC_DAT, 16'h0000);
    @(negedge clk); check("ctrl_no_sram_re", {31'b0, sram_re}, 32'd0);
    tick();
    dat_rw_addr = 16'h8000; push_rd(SRC_DAT, 16'hEEEE);
    @(negedge clk); check("vram_no_sram_re", {31'b0, sram_re}, 32'd0);
    tick();
    dat_rw_addr = 16'h1234; push_rd(SRC_DAT, 16'hEEEE);
    @(negedge clk); check("unmap_no_sram_re", {31'b0, sram_re}, 32'd0);
    tick();
    dat_rd_req = 1'b0;
    repeat (3) tick();

    // reset_n asserted while a fetch rdy is outstanding
    ins_rd_addr = 16'h0010; ins_rd_req = 1'b1;
    tick();
    reset_n = 1'b0; ins_rd_req = 1'b0;
    #1;
    check("async_rst_rdy", {31'b0, ins_rd_rdy}, 32'd0);
    check("async_rst_re", {31'b0, sram_re}, 32'd0);
    repeat (2) tick();
    reset_n = 1'b1;
    repeat (4) tick();

    check("rd_queue_drained", rd_q.size(), 32'd0);
    check("wr_queue_drained", wr_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
